uart_word_io: RTL and testbench

UART_WORD_IO -- requirements
Module: uart_word_io

---
 rtl/uart_word_io.sv | 179 +++++++++++++++++
 tb/tb_uart_word_io.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_io.sv
// Packs UART bytes into words for a core input port or an instruction-memory loader, and sends core words out byte by byte.
// Optional inter-byte RX timeout is enabled by defining UART_WORD_IO_RX_TIMEOUT_EN.
module uart_word_io #(
  parameter int unsigned WORD_BYTES      = 4,
  parameter int unsigned IO_MSB_FIRST    = 1,
  parameter int unsigned LOAD_MSB_FIRST  = 0,
  parameter int unsigned LOAD_ADDR_WIDTH = 5,
  parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  output logic [7:0]                 tx_data,
  output logic                       tx_enable,
  input  logic                       tx_ready,
  input  logic                       in_req,
  output logic [8*WORD_BYTES-1:0]    in_word,
  output logic                       in_done,
  input  logic                       out_req,
  input  logic [8*WORD_BYTES-1:0]    out_word,
  output logic                       out_done,
  output logic                       out_busy,
  input  logic                       load_start,
  input  logic                       load_stop,
  output logic                       loading,
  output logic                       load_we,
  output logic [LOAD_ADDR_WIDTH-1:0] load_addr,
  output logic [8*WORD_BYTES-1:0]    load_data,
  output logic                       rx_drop,
  output logic                       rx_timeout
);

  localparam int unsigned W     = 8 * WORD_BYTES;
  localparam int unsigned CNT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_BYTES - 1);

  // ---------------- RX word assembly ----------------
  logic [CNT_W-1:0] rx_cnt;
  logic [W-1:0]     rx_buf;
  logic [W-1:0]     rx_word_c;
  logic [CNT_W-1:0] rx_sel_c;
  logic             rx_msb_c;
  logic             has_cons_c;
  logic             tmo_c;

  always_comb begin
    has_cons_c = loading | in_req;
    rx_msb_c   = loading ? (LOAD_MSB_FIRST != 0) : (IO_MSB_FIRST != 0);
    rx_sel_c   = rx_msb_c ? (LAST - rx_cnt) : rx_cnt;
    rx_word_c  = rx_buf;
    rx_word_c[{rx_sel_c, 3'b000} +: 8] = rx_data;
  end

`ifdef UART_WORD_IO_RX_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] tmr;

  assign tmo_c = (rx_cnt != '0) && !rx_valid && (tmr == TMR_W'(TIMEOUT_CYCLES - 1));

  // Idle time since the last byte of a partial word
  always_ff @(posedge CLK) begin
    if (RST || rx_valid || (rx_cnt == '0) || tmo_c) tmr <= '0;
    else                                            tmr <= tmr + TMR_W'(1);
  end
`else
  assign tmo_c = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_cnt     <= '0;
      rx_buf     <= '0;
      in_word    <= '0;
      in_done    <= 1'b0;
      loading    <= 1'b0;
      load_we    <= 1'b0;
      load_addr  <= '0;
      load_data  <= '0;
      rx_drop    <= 1'b0;
      rx_timeout <= 1'b0;
    end else begin
      in_done    <= 1'b0;
      load_we    <= 1'b0;
      rx_timeout <= rx_timeout | tmo_c;
      if (load_we) load_addr <= load_addr + LOAD_ADDR_WIDTH'(1);

      if (!has_cons_c) begin
        rx_cnt <= '0;
        if (rx_valid) rx_drop <= 1'b1;
      end else if (rx_valid) begin
        rx_buf <= rx_word_c;
        if (rx_cnt == LAST) begin
          rx_cnt <= '0;
          if (loading) begin
            load_we   <= 1'b1;
            load_data <= rx_word_c;
          end else begin
            in_done <= 1'b1;
            in_word <= rx_word_c;
          end
        end else begin
          rx_cnt <= rx_cnt + CNT_W'(1);
        end
      end

      if (tmo_c) rx_cnt <= '0;

      // Load-mode control overrides the byte counter; stop beats start
      if (load_stop) begin
        loading <= 1'b0;
        rx_cnt  <= '0;
      end else if (load_start && !loading) begin
        loading   <= 1'b1;
        load_addr <= '0;
        rx_cnt    <= '0;
      end
    end
  end

  // ---------------- TX engine ----------------
  typedef enum logic [1:0] {IDLE, SEND, WAIT_LOW, WAIT_HIGH} tx_state_t;

  tx_state_t        state, state_n;
  logic [W-1:0]     tx_word, word_n;
  logic [CNT_W-1:0] tx_idx, idx_n;
  logic [CNT_W-1:0] tx_sel_c;
  logic [7:0]       tx_byte_c;
  logic             done_c;

  always_comb begin
    state_n = state;
    word_n  = tx_word;
    idx_n   = tx_idx;
    done_c  = 1'b0;
    case (state)
      IDLE: if (out_req) begin
        state_n = SEND;
        word_n  = out_word;
        idx_n   = '0;
      end
      SEND:     state_n = WAIT_LOW;
      WAIT_LOW: if (!tx_ready) state_n = WAIT_HIGH;
      WAIT_HIGH: if (tx_ready) begin
        if (tx_idx == LAST) begin
          state_n = IDLE;
          done_c  = 1'b1;
        end else begin
          state_n = SEND;
          idx_n   = tx_idx + CNT_W'(1);
        end
      end
      default:  state_n = IDLE;
    endcase
    tx_sel_c  = (IO_MSB_FIRST != 0) ? (LAST - idx_n) : idx_n;
    tx_byte_c = word_n[{tx_sel_c, 3'b000} +: 8];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      tx_word   <= '0;
      tx_idx    <= '0;
      tx_data   <= '0;
      tx_enable <= 1'b0;
      out_done  <= 1'b0;
      out_busy  <= 1'b0;
    end else begin
      state     <= state_n;
      tx_word   <= word_n;
      tx_idx    <= idx_n;
      tx_enable <= (state_n == SEND);
      if (state_n == SEND) tx_data <= tx_byte_c;
      out_done  <= done_c;
      out_busy  <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_word_io.sv
// Directed bench for uart_word_io: RX word assembly, loader with address wrap, TX engine, drop, reset and timeout.
module tb_uart_word_io;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_enable;
  logic        tx_ready;
  logic        in_req;
  logic [31:0] in_word;
  logic        in_done;
  logic        out_req;
  logic [31:0] out_word;
  logic        out_done;
  logic        out_busy;
  logic        load_start;
  logic        load_stop;
  logic        loading;
  logic        load_we;
  logic [1:0]  load_addr;
  logic [31:0] load_data;
  logic        rx_drop;
  logic        rx_timeout;

  uart_word_io #(
    .WORD_BYTES(4), .IO_MSB_FIRST(1), .LOAD_MSB_FIRST(0),
    .LOAD_ADDR_WIDTH(2), .TIMEOUT_CYCLES(100)
  ) dut (
    .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_enable(tx_enable), .tx_ready(tx_ready),
    .in_req(in_req), .in_word(in_word), .in_done(in_done),
    .out_req(out_req), .out_word(out_word), .out_done(out_done), .out_busy(out_busy),
    .load_start(load_start), .load_stop(load_stop), .loading(loading),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .rx_drop(rx_drop), .rx_timeout(rx_timeout)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int n_in_done = 0, n_load_we = 0, n_out_done = 0, n_txen = 0;
  logic [7:0] cap[$];

  typedef struct {
    bit          is_load;
    logic [31:0] sent;      // first byte on the wire in [31:24]
    logic [31:0] exp_word;
    logic [1:0]  exp_addr;
  } vec_t;

  vec_t vecs[7];

  always @(posedge CLK) begin
    if (in_done)   n_in_done++;
    if (load_we)   n_load_we++;
    if (out_done)  n_out_done++;
    if (tx_enable) n_txen++;
  end

  // UART sender model: accept a byte, stay busy for a few cycles
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(negedge CLK);
      if (tx_enable) begin
        cap.push_back(tx_data);
        tx_ready = 1'b0;
        repeat (3) @(negedge CLK);
        tx_ready = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge CLK);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      if (k != 0) tick(2);
      send_byte(w[8*(3-k) +: 8]);
    end
  endtask

  task automatic pulse_out(input logic [31:0] w);
    out_word = w;
    out_req  = 1'b1;
    tick(1);
    out_req  = 1'b0;
    out_word = '0;
  endtask

  task automatic wait_done(input int target);
    int k = 0;
    while (n_out_done < target && k < 500) begin
      tick(1);
      k++;
    end
    check("tx_done_wait", 64'(n_out_done >= target), 64'd1);
  endtask

  initial begin
    bit load_on = 1'b0;
    int k;

    vecs[0] = '{1'b0, 32'h12345678, 32'h12345678, 2'd0};
    vecs[1] = '{1'b0, 32'hA500FF3C, 32'hA500FF3C, 2'd0};
    vecs[2] = '{1'b1, 32'h78563412, 32'h12345678, 2'd0};
    vecs[3] = '{1'b1, 32'hEFBEADDE, 32'hDEADBEEF, 2'd1};
    vecs[4] = '{1'b1, 32'h01020304, 32'h04030201, 2'd2};
    vecs[5] = '{1'b1, 32'h11223344, 32'h44332211, 2'd3};
    vecs[6] = '{1'b1, 32'hAABBCCDD, 32'hDDCCBBAA, 2'd0};

    RST = 1'b1; rx_data = '0; rx_valid = 1'b0; in_req = 1'b0;
    out_req = 1'b0; out_word = '0; load_start = 1'b0; load_stop = 1'b0;
    tick(3);
    check("rst_in_word", in_word, 0);
    check("rst_loading", loading, 0);
    check("rst_load_addr", load_addr, 0);
    check("rst_out_busy", out_busy, 0);
    check("rst_tx_enable", tx_enable, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_rx_drop", rx_drop, 0);
    check("rst_rx_timeout", rx_timeout, 0);
    RST = 1'b0;
    tick(1);

    for (int i = 0; i < 7; i++) begin
      if (!vecs[i].is_load) begin
        in_req = 1'b1;
      end else begin
        in_req = 1'b0;
        if (!load_on) begin
          load_start = 1'b1;
          tick(1);
          load_start = 1'b0;
          tick(1);
          load_on = 1'b1;
          check("load_start_loading", loading, 1);
          check("load_start_addr", load_addr, 0);
        end
      end
      send_word(vecs[i].sent);
      if (vecs[i].is_load) begin
        check($sformatf("v%0d_load_we", i), load_we, 1);
        check($sformatf("v%0d_load_data", i), load_data, vecs[i].exp_word);
        check($sformatf("v%0d_load_addr", i), load_addr, vecs[i].exp_addr);
        tick(1);
        check($sformatf("v%0d_load_we_pulse", i), load_we, 0);
      end else begin
        check($sformatf("v%0d_in_done", i), in_done, 1);
        check($sformatf("v%0d_in_word", i), in_word, vecs[i].exp_word);
        tick(1);
        check($sformatf("v%0d_in_done_pulse", i), in_done, 0);
      end
      tick(2);
    end
    check("load_addr_after_wrap", load_addr, 1);
    check("n_load_we", n_load_we, 5);
    check("n_in_done", n_in_done, 2);

    // Partial word discarded by load_stop
    send_byte(8'h55); tick(2); send_byte(8'h66); tick(2);
    load_stop = 1'b1; tick(1); load_stop = 1'b0; tick(3);
    check("stop_loading", loading, 0);
    check("stop_addr_kept", load_addr, 1);
    check("stop_no_we", n_load_we, 5);
    in_req = 1'b1;
    send_word(32'h9ABCDEF0);
    check("after_stop_in_done", in_done, 1);
    check("after_stop_in_word", in_word, 32'h9ABCDEF0);
    in_req = 1'b0;
    tick(2);

    // TX word, with a second request while busy that must be ignored
    cap.delete();
    pulse_out(32'hCAFEBABE);
    check("tx_busy", out_busy, 1);
    tick(5);
    pulse_out(32'h12345678);
    wait_done(1);
    tick(5);
    check("tx1_count", cap.size(), 4);
    check("tx1_b0", cap[0], 8'hCA);
    check("tx1_b1", cap[1], 8'hFE);
    check("tx1_b2", cap[2], 8'hBA);
    check("tx1_b3", cap[3], 8'hBE);
    check("tx1_enables", n_txen, 4);
    check("tx1_done", n_out_done, 1);
    check("tx1_idle", out_busy, 0);

    cap.delete();
    pulse_out(32'h0102A0FF);
    wait_done(2);
    tick(5);
    check("tx2_count", cap.size(), 4);
    check("tx2_b0", cap[0], 8'h01);
    check("tx2_b1", cap[1], 8'h02);
    check("tx2_b2", cap[2], 8'hA0);
    check("tx2_b3", cap[3], 8'hFF);

    // Byte with no consumer
    send_byte(8'h42);
    tick(1);
    check("drop_set", rx_drop, 1);
    tick(10);
    check("drop_sticky", rx_drop, 1);
    check("drop_no_in_done", n_in_done, 3);

    // Reset mid-word
    in_req = 1'b1;
    send_byte(8'hAA); tick(2); send_byte(8'hBB); tick(1);
    RST = 1'b1; tick(1); RST = 1'b0;
    check("rst_clears_drop", rx_drop, 0);
    check("rst_clears_in_word", in_word, 0);
    send_word(32'h01020304);
    check("post_rst_in_done", in_done, 1);
    check("post_rst_in_word", in_word, 32'h01020304);
    tick(3);
    check("post_rst_n_in_done", n_in_done, 4);
    in_req = 1'b0;

    // Reset mid-transmission
    cap.delete();
    pulse_out(32'h11223344);
    k = 0;
    while (cap.size() < 2 && k < 200) begin
      tick(1);
      k++;
    end
    check("midtx_two_bytes", cap.size(), 2);
    RST = 1'b1; tick(1); RST = 1'b0;
    check("midtx_busy", out_busy, 0);
    check("midtx_enable", tx_enable, 0);
    tick(40);
    check("midtx_no_done", n_out_done, 2);
    check("midtx_no_more_bytes", cap.size(), 2);
    check("midtx_enables", n_txen, 10);

    // Inter-byte idle gap on a partial word
    in_req = 1'b1;
    send_byte(8'hAA); tick(2); send_byte(8'hBB);
    tick(150);
`ifdef UART_WORD_IO_RX_TIMEOUT_EN
    check("timeout_flag", rx_timeout, 1);
    send_word(32'h01020304);
    check("timeout_in_done", in_done, 1);
    check("timeout_in_word", in_word, 32'h01020304);
`else
    check("no_timeout_flag", rx_timeout, 0);
    send_byte(8'hCC); tick(2); send_byte(8'hDD);
    check("persist_in_done", in_done, 1);
    check("persist_in_word", in_word, 32'hAABBCCDD);
`endif
    in_req = 1'b0;
    tick(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
